// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: CTR-mode sequencer wrapped around an AES encipher core.
// Builds counter blocks, strobes the cipher, XORs each keystream block with
// one host word and presents the result on a valid/ready output.
// Optional build macro AES_CTR_PREFETCH_EN: keystream for the current
// counter is generated ahead into ks_reg so an accepted word is answered on
// the next cycle. In that build init is honoured whenever no result is
// pending; a generation already in flight completes and is discarded.
module aes_ctr_stream #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] iv,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         ctr_wrap,
  output logic         cipher_next,
  output logic [127:0] cipher_block,
  input  logic [127:0] cipher_result,
  input  logic         cipher_ready
);

  // Only the low CTR_WIDTH bits count; the rest is the fixed nonce.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_SYNC,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] ctr_reg;
  logic         loaded;
  logic         init_take;
  logic         accept;

  function automatic logic [127:0] ctr_increment(input logic [127:0] c);
    return (c & ~CTR_MASK) | ((c + 128'd1) & CTR_MASK);
  endfunction

  function automatic logic ctr_at_max(input logic [127:0] c);
    return (c & CTR_MASK) == CTR_MASK;
  endfunction

`ifdef AES_CTR_PREFETCH_EN
  logic [127:0] ks_reg;
  logic         ks_valid;
  logic         discard;

  assign init_take = init & ~out_valid;
  assign accept    = in_valid & in_ready & ~init;
`else
  logic [127:0] data_reg;

  assign init_take = init & (state == S_IDLE) & ~out_valid;
  assign accept    = in_valid & in_ready & ~init;
`endif

  // The cipher always sees the live counter; it only moves in RESULT or on init.
  assign cipher_block = ctr_reg;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode for the block sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef AES_CTR_PREFETCH_EN
      S_IDLE:   if (!init_take && loaded && !ks_valid) state_nxt = S_NEXT;
`else
      S_IDLE:   if (accept) state_nxt = S_NEXT;
`endif
      S_NEXT:   state_nxt = S_SYNC;
      // cipher_ready only drops one cycle after next, so skip a cycle here.
      S_SYNC:   state_nxt = S_WAIT;
      S_WAIT:   if (cipher_ready) state_nxt = S_RESULT;
      S_RESULT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: cipher strobe and host input handshake.
  always_comb begin
    cipher_next = (state == S_NEXT);
`ifdef AES_CTR_PREFETCH_EN
    in_ready    = (state == S_IDLE) & loaded & ~out_valid & ks_valid;
`else
    in_ready    = (state == S_IDLE) & loaded & ~out_valid;
`endif
  end

  // Counter, sticky wrap flag, data capture and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctr_reg   <= '0;
      loaded    <= 1'b0;
      ctr_wrap  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef AES_CTR_PREFETCH_EN
      ks_reg    <= '0;
      ks_valid  <= 1'b0;
      discard   <= 1'b0;
`else
      data_reg  <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

`ifdef AES_CTR_PREFETCH_EN
      if (init_take) begin
        ctr_reg  <= iv;
        loaded   <= 1'b1;
        ctr_wrap <= 1'b0;
        ks_valid <= 1'b0;
        // A block already handed to the cipher belongs to the old counter.
        discard  <= (state == S_NEXT) || (state == S_SYNC) || (state == S_WAIT);
      end else if (state == S_RESULT) begin
        discard <= 1'b0;
        if (!discard) begin
          ctr_reg <= ctr_increment(ctr_reg);
          if (ctr_at_max(ctr_reg)) ctr_wrap <= 1'b1;
        end
      end

      if (state == S_WAIT && cipher_ready && !discard && !init_take) begin
        ks_reg   <= cipher_result;
        ks_valid <= 1'b1;
      end

      if (accept) begin
        out_data  <= in_data ^ ks_reg;
        out_valid <= 1'b1;
        ks_valid  <= 1'b0;
      end
`else
      if (init_take) begin
        ctr_reg  <= iv;
        loaded   <= 1'b1;
        ctr_wrap <= 1'b0;
      end else if (state == S_RESULT) begin
        ctr_reg <= ctr_increment(ctr_reg);
        if (ctr_at_max(ctr_reg)) ctr_wrap <= 1'b1;
      end

      if (accept) data_reg <= in_data;

      if (state == S_WAIT && cipher_ready) begin
        out_data  <= data_reg ^ cipher_result;
        out_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream (default build, CTR_WIDTH=32): behavioural cipher
// stand-in, counter-mode reference model and a queue-based scoreboard.
module tb_aes_ctr_stream;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic [127:0] iv;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         ctr_wrap;
  logic         cipher_next;
  logic [127:0] cipher_block;
  logic [127:0] cipher_result;
  logic         cipher_ready;

  int checks   = 0;
  int failures = 0;

  int rdy_mode = 1;
  int lat_min  = 1;
  int lat_max  = 4;

  logic [127:0] exp_q[$];
  logic [127:0] ctr_m  = '0;
  bit           wrap_m = 1'b0;

  int           xfers    = 0;
  int           nxt_cnt  = 0;
  logic [127:0] last_out = '0;
  logic         hold_v   = 1'b0;
  logic         nxt_prev = 1'b0;
  logic [127:0] hold_d   = '0;
  logic [127:0] mon_e;

  int           busy;
  logic [127:0] blk_l;

  aes_ctr_stream #(.CTR_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init         (init),
    .iv           (iv),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .ctr_wrap     (ctr_wrap),
    .cipher_next  (cipher_next),
    .cipher_block (cipher_block),
    .cipher_result(cipher_result),
    .cipher_ready (cipher_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keystream of the stand-in cipher. The two AES-128 reference blocks give
  // the FIPS-197 / SP800-38A keystream; other blocks get a keyed mix.
  function automatic logic [127:0] ks_of(input logic [127:0] b);
    if (b == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff)
      return 128'h6bc1bee22e409f96e93d7e117393172a ^ 128'h874d6191b620e3261bef6864990db6ce;
    if (b == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00)
      return 128'hae2d8a571e03ac9c9eb76fac45af8e51 ^ 128'h9806f66b7970fdff8617187bb9fffdff;
    return {b[63:0], b[127:64]} ^ (b * 128'h9e3779b97f4a7c15f39cc0605cedc835)
           ^ 128'h0123456789abcdef0f1e2d3c4b5a6978;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Encipher stand-in: ready drops the cycle after next, result after a latency.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cipher_ready  <= 1'b1;
      cipher_result <= '0;
      busy          <= 0;
      blk_l         <= '0;
    end else if (cipher_next) begin
      cipher_ready <= 1'b0;
      blk_l        <= cipher_block;
      busy         <= $urandom_range(lat_max, lat_min);
    end else if (!cipher_ready) begin
      if (busy <= 1) begin
        cipher_ready  <= 1'b1;
        cipher_result <= ks_of(blk_l);
      end else begin
        busy <= busy - 1;
      end
    end
  end

  // Monitor: scoreboard pop, output hold stability, next-strobe width.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
      end
      if (cipher_next) begin
        nxt_cnt++;
        check("next_width", nxt_prev, 0);
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          timeout("unexpected_output");
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e);
        end
        last_out = out_data;
      end
      hold_v   = out_valid && !out_ready;
      hold_d   = out_data;
      nxt_prev = cipher_next;
    end else begin
      hold_v   = 1'b0;
      nxt_prev = 1'b0;
    end
  end

  // Downstream ready: 0 = stall, 1 = always, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [127:0] v, input bit with_valid, input logic [127:0] d);
    init = 1'b1;
    iv   = v;
    if (with_valid) begin
      in_valid = 1'b1;
      in_data  = d;
    end
    step();
    init     = 1'b0;
    in_valid = 1'b0;
    ctr_m    = v;
    wrap_m   = 1'b0;
  endtask

  // Offer one word; the reference model predicts its result at acceptance.
  task automatic send(input logic [127:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      timeout("send_accept");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(d ^ ks_of(ctr_m));
    if (ctr_m[31:0] == 32'hffffffff) wrap_m = 1'b1;
    ctr_m = {ctr_m[127:32], ctr_m[31:0] + 32'd1};
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) timeout("wait_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held, up, d;
    int nb, xb, n;
    reset_n  = 1'b1;
    init     = 1'b0;
    iv       = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #1 reset_n = 1'b0;
    repeat (2) step();

    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ctr_wrap", ctr_wrap, 0);
    check("rst_cipher_next", cipher_next, 0);
    check("rst_cipher_block", cipher_block, 0);
    step();
    reset_n = 1'b1;

    // Words offered before any init must be refused.
    check("pre_init_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = rand128();
    repeat (4) step();
    in_valid = 1'b0;
    check("pre_init_no_next", nxt_cnt, 0);

    // AES-128 reference vectors.
    do_init(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 1'b0, '0);
    check("vec_block0", cipher_block, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    nb = nxt_cnt;
    send(128'h6bc1bee22e409f96e93d7e117393172a);
    wait_idle();
    check("vec1_out", last_out, 128'h874d6191b620e3261bef6864990db6ce);
    check("vec1_pulses", nxt_cnt - nb, 1);
    check("vec2_block", cipher_block, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
    send(128'hae2d8a571e03ac9c9eb76fac45af8e51);
    wait_idle();
    check("vec2_out", last_out, 128'h9806f66b7970fdff8617187bb9fffdff);
    check("vec2_wrap", ctr_wrap, 0);

    // Counter wrap in the low 32 bits.
    up = rand128();
    do_init({up[127:32], 32'hffffffff}, 1'b0, '0);
    send(rand128());
    wait_idle();
    check("wrap_block", cipher_block, {up[127:32], 32'h00000000});
    check("wrap_flag", ctr_wrap, wrap_m);
    send(rand128());
    wait_idle();
    check("wrap_sticky", ctr_wrap, 1);
    check("wrap_block2", cipher_block, ctr_m);

    // Backpressure: stall 20 cycles; init and new data offered meanwhile are ignored.
    rdy_mode = 0;
    step();
    send(rand128());
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeout("bp_out_valid");
    held     = out_data;
    nb       = nxt_cnt;
    xb       = xfers;
    init     = 1'b1;
    iv       = rand128();
    in_valid = 1'b1;
    in_data  = rand128();
    step();
    init = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    check("bp_no_next", nxt_cnt, nb);
    check("bp_wrap_kept", ctr_wrap, wrap_m);
    rdy_mode = 1;
    repeat (6) step();
    check("bp_one_xfer", xfers - xb, 1);
    check("bp_released", out_valid, 0);
    check("bp_block", cipher_block, ctr_m);

    // init together with in_valid: init wins, word refused.
    d = rand128();
    do_init(rand128(), 1'b1, rand128());
    nb = nxt_cnt;
    check("iv_block", cipher_block, ctr_m);
    check("iv_wrap_clear", ctr_wrap, 0);
    repeat (8) begin
      check("iv_no_output", out_valid, 0);
      step();
    end
    check("iv_no_next", nxt_cnt, nb);
    send(d);
    wait_idle();

    // Reset asserted while the sequencer waits on the cipher.
    lat_min = 10;
    lat_max = 10;
    send(rand128());
    step();
    step();
    check("wait_no_output", out_valid, 0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_ctr_wrap", ctr_wrap, 0);
    check("mid_rst_cipher_next", cipher_next, 0);
    check("mid_rst_cipher_block", cipher_block, 0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    lat_min = 1;
    lat_max = 6;
    nb = nxt_cnt;
    in_valid = 1'b1;
    in_data  = rand128();
    repeat (4) begin
      check("post_rst_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    check("post_rst_no_next", nxt_cnt, nb);

    // Randomized traffic near the wrap point with random backpressure and latency.
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      up = rand128();
      do_init({up[127:32], 32'hffffffff - 32'($urandom_range(6, 0))}, 1'b0, '0);
      for (int k = 0; k < 12; k++) begin
        send(rand128());
        repeat ($urandom_range(3, 0)) step();
      end
      wait_idle();
      check("rand_block", cipher_block, ctr_m);
      check("rand_wrap", ctr_wrap, wrap_m);
    end

    rdy_mode = 1;
    wait_idle();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
